// File: rtl/seg7_pkg.sv
// Shared constants, font table and parameter-legality helper for the seven-segment display blocks.
package seg7_pkg;

   localparam logic [7:0] SEG_OFF      = 8'hFF;
   localparam int         DIGITS_MIN   = 1;
   localparam int         DIGITS_MAX   = 16;
   localparam int         SCAN_DIV_MIN = 4;

   // Active-low gfedcba patterns for the 16 hex glyphs.
   function automatic logic [6:0] font7(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   function automatic bit params_legal(input int digits, input int scan_div);
      return (digits >= DIGITS_MIN) && (digits <= DIGITS_MAX) && (scan_div >= SCAN_DIV_MIN);
   endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex nibble to active-low gfedcba pattern, shared by display blocks.
module seg7_hex_font
   import seg7_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg7
);

   assign o_seg7 = font7(i_nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan driver with hex/raw modes, blanking, dp and PWM brightness.
// Optional leading-zero blanking in hex mode when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000,
   parameter int PWM_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  we,
   input  logic [4*DIGITS-1:0]   hex_i,
   input  logic [8*DIGITS-1:0]   raw_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  raw_mode_i,
   input  logic [DIGITS-1:0]     blank_i,
   input  logic [PWM_BITS-1:0]   bright_i,
   output logic [7:0]            seg_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  frame_o
);

   localparam int               IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int               PRE_W   = $clog2(SCAN_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

   generate
      if (!params_legal(DIGITS, SCAN_DIV)) begin : g_bad_params
         $error("seg7_scan_ctrl: DIGITS must be 1..16 and SCAN_DIV >= 4");
      end
   endgenerate

   logic [4*DIGITS-1:0] r_hex;
   logic [8*DIGITS-1:0] r_raw;
   logic [DIGITS-1:0]   r_dp;
   logic                r_raw_mode;
   logic [PRE_W-1:0]    r_presc;
   logic [IDX_W-1:0]    r_idx;
   logic [PWM_BITS-1:0] r_pwm;
   logic [7:0]          r_seg;
   logic [DIGITS-1:0]   r_an;
   logic                r_frame;

   logic [3:0]          w_nib;
   logic [6:0]          w_font;
   logic [7:0]          w_seg_next;
   logic [DIGITS-1:0]   w_blank_mask;
   logic                w_slot_start;
   logic                w_an_on;

   assign w_nib = r_hex[{r_idx, 2'b00} +: 4];

   seg7_hex_font u_font (
      .i_nib  (w_nib),
      .o_seg7 (w_font)
   );

   assign w_seg_next = r_raw_mode ? r_raw[{r_idx, 3'b000} +: 8] : {~r_dp[r_idx], w_font};

`ifdef SEG7_LZ_BLANK_EN
   logic [DIGITS-1:0] w_lz_mask;
   logic              w_zero_run;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_lz_mask  = '0;
      w_zero_run = ~r_raw_mode;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_zero_run   = w_zero_run & (r_hex[4*k +: 4] == 4'h0);
         w_lz_mask[k] = w_zero_run;
      end
   end

   assign w_blank_mask = blank_i | w_lz_mask;
`else
   assign w_blank_mask = blank_i;
`endif

   // Prescaler 0 is the dead-time cycle: anodes off while the segment pattern changes.
   assign w_slot_start = (r_presc == '0);
   assign w_an_on      = !w_slot_start && !w_blank_mask[r_idx] && (r_pwm <= bright_i);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_hex      <= '0;
         r_raw      <= '0;
         r_dp       <= '0;
         r_raw_mode <= 1'b0;
         r_presc    <= '0;
         r_idx      <= '0;
         r_pwm      <= '0;
         r_seg      <= SEG_OFF;
         r_an       <= '1;
         r_frame    <= 1'b0;
      end else begin
         if (we) begin
            r_hex      <= hex_i;
            r_raw      <= raw_i;
            r_dp       <= dp_i;
            r_raw_mode <= raw_mode_i;
         end

         r_pwm   <= r_pwm + 1'b1;
         r_frame <= 1'b0;
         if (r_presc == PRE_MAX) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            r_frame <= (r_idx == IDX_MAX);
         end else begin
            r_presc <= r_presc + 1'b1;
         end

         // Snapshot once per slot so a mid-slot write cannot tear the displayed digit.
         if (w_slot_start) r_seg <= w_seg_next;
         r_an <= w_an_on ? ~(DIGITS'(1) << r_idx) : '1;
      end
   end

   assign seg_o   = r_seg;
   assign an_o    = r_an;
   assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (DIGITS=8; SCAN_DIV=4, plus a SCAN_DIV=64 copy for PWM).
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        we = 1'b0;
   logic [31:0] hex_i = '0;
   logic [63:0] raw_i = '0;
   logic [7:0]  dp_i = '0;
   logic        raw_mode_i = 1'b0;
   logic [7:0]  blank_i = '0;
   logic [3:0]  bright_i = 4'hF;
   logic [7:0]  seg_o, an_o, seg_b, an_b;
   logic        frame_o, frame_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] cap_an  [0:64];
   logic [7:0] cap_seg [0:64];
   logic       cap_fr  [0:64];

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .PWM_BITS(4)) dut (
      .clk(clk), .rstn(rstn), .we(we), .hex_i(hex_i), .raw_i(raw_i), .dp_i(dp_i),
      .raw_mode_i(raw_mode_i), .blank_i(blank_i), .bright_i(bright_i),
      .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
   );

   seg7_scan_ctrl #(.DIGITS(8), .SCAN_DIV(64), .PWM_BITS(4)) dut_b (
      .clk(clk), .rstn(rstn), .we(we), .hex_i(hex_i), .raw_i(raw_i), .dp_i(dp_i),
      .raw_mode_i(raw_mode_i), .blank_i(blank_i), .bright_i(bright_i),
      .seg_o(seg_b), .an_o(an_b), .frame_o(frame_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_we();
      @(negedge clk); we = 1'b1;
      @(negedge clk); we = 1'b0;
   endtask

   // Returns at the negedge of the cycle in which the selected frame pulse is high.
   task automatic goto_frame(input bit use_b, input int limit);
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n++;
         seen = use_b ? frame_b : frame_o;
      end
      if (!seen) check("frame_timeout", 32'd0, 32'd1);
   endtask

   // Records len cycles; optionally raises we for the single cycle j == wr_j.
   task automatic capture(input bit use_b, input int len, input int wr_j);
      for (int j = 1; j <= len; j++) begin
         @(negedge clk);
         cap_an[j]  = use_b ? an_b : an_o;
         cap_seg[j] = use_b ? seg_b : seg_o;
         cap_fr[j]  = use_b ? frame_b : frame_o;
         we = (j == wr_j);
      end
      we = 1'b0;
   endtask

   function automatic int count_low(input int k);
      int c = 0;
      for (int j = 1; j <= 32; j++)
         if (cap_an[j] == ~(8'h01 << k)) c++;
      return c;
   endfunction

   logic [7:0] exp_hex [8] = '{8'h0E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

   initial begin
      int c;

      // Power-on, run mid-scan, then reset asynchronously.
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (13) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("rst_seg", seg_o, 8'hFF);
      check("rst_an", an_o, 8'hFF);
      check("rst_frame", frame_o, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_dead_an", an_o, 8'hFF);
      check("post_rst_seg", seg_o, 8'hC0);
      @(negedge clk);
      check("post_rst_first_an", an_o, 8'hFE);

      // Hex scan.
      hex_i = 32'h89ABCDEF; dp_i = 8'h01; raw_mode_i = 1'b0; bright_i = 4'hF;
      pulse_we();
      goto_frame(1'b0, 100);
      capture(1'b0, 32, 0);
      check("hex_dead_an", cap_an[1], 8'hFF);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("hex_seg_d%0d", k), cap_seg[4*k+2], exp_hex[k]);
         check($sformatf("hex_low_d%0d", k), count_low(k), 3);
      end
      check("frame_period", cap_fr[32], 1'b1);
      c = 0;
      for (int j = 1; j < 32; j++) c += cap_fr[j];
      check("frame_single", c, 0);

      // Raw mode.
      for (int k = 0; k < 8; k++) raw_i[8*k +: 8] = 8'h10 + 8'(k);
      raw_i[23:16] = 8'h5A;
      raw_mode_i = 1'b1;
      pulse_we();
      goto_frame(1'b0, 100);
      capture(1'b0, 32, 0);
      check("raw_d2_an", cap_an[10], 8'hFB);
      check("raw_d2_seg", cap_seg[10], 8'h5A);
      check("raw_d0_seg", cap_seg[2], 8'h10);

      // Blanking and mid-slot update.
      hex_i = 32'h10000000; dp_i = 8'h00; raw_mode_i = 1'b0; blank_i = 8'h80;
      pulse_we();
      goto_frame(1'b0, 100);
      capture(1'b0, 32, 0);
      check("blank_d7_low", count_low(7), 0);
      check("blank_d7_an", cap_an[31], 8'hFF);
      check("blank_d7_seg", cap_seg[31], 8'hF9);
      hex_i = 32'h10007000;
      capture(1'b0, 32, 14);
      check("upd_same_slot_seg", cap_seg[15], 8'hC0);
      check("upd_same_slot_an", cap_an[15], 8'hF7);
      capture(1'b0, 32, 0);
      check("upd_next_visit_seg", cap_seg[14], 8'hF8);
      check("upd_other_digit", cap_seg[10], 8'hC0);

      // PWM brightness on the slow-scan copy.
      blank_i = 8'h00; bright_i = 4'd3;
      goto_frame(1'b1, 600);
      capture(1'b1, 64, 0);
      check("pwm_seg", cap_seg[2], 8'hC0);
      check("pwm_on_p0", cap_an[17], 8'hFE);
      check("pwm_off_p4", cap_an[21], 8'hFF);
      c = 0;
      for (int j = 17; j <= 32; j++) if (cap_an[j] == 8'hFE) c++;
      check("pwm_4_of_16", c, 4);
      c = 0;
      for (int j = 1; j <= 64; j++) if (cap_an[j] == 8'hFE) c++;
      check("pwm_slot_total", c, 15);
      bright_i = 4'hF;

`ifdef SEG7_LZ_BLANK_EN
      // Leading-zero blanking.
      hex_i = 32'h00000120;
      pulse_we();
      goto_frame(1'b0, 100);
      capture(1'b0, 32, 0);
      for (int k = 0; k < 8; k++)
         check($sformatf("lz_low_d%0d", k), count_low(k), (k < 3) ? 3 : 0);
      hex_i = 32'h0;
      pulse_we();
      goto_frame(1'b0, 100);
      capture(1'b0, 32, 0);
      check("lz_zero_d0_low", count_low(0), 3);
      check("lz_zero_d0_seg", cap_seg[2], 8'hC0);
      c = 0;
      for (int j = 1; j <= 32; j++) if (cap_an[j] != 8'hFF) c++;
      check("lz_zero_only_d0", c, 3);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
